memwb_skid_stage: RTL and testbench
===================================

# memwb_skid_stage

Parametrised MEM/WB pipeline stage. It replaces the plain free-running MEM/WB latch with a valid/ready-handshaked two-entry skid buffer. It adds synchronous flush, asynchronous reset, and a registered write-back result mux with qualified register-file write enable. It sits between the data-memory stage and the register-file write port, so the write-back stage can stall without a combinational ready path back into MEM.

## Interface

Parameters:
- WB_W, default 2: width of the WB control field. Bit 1 is RegWrite, bit 0 is MemToReg; any bits above 1 pass through untouched.
- DATA_W, default 32: width of the memory read data and the ALU address/result.
- REG_W, default 5: width of the destination register index.
- SUPPRESS_R0, default 1: when 1, writes to register index 0 never assert wb_we.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous flush; discards all held entries.
- in_valid, input, 1: MEM side presents an entry.
- in_ready, output, 1: stage can accept an entry; driven only from registered state.
- in_wb, input, WB_W: WB control.
- in_dato, input, DATA_W: data read from memory.
- in_dir, input, DATA_W: ALU result / address.
- in_reg, input, REG_W: destination register.
- out_valid, output, 1: head entry is valid.
- out_ready, input, 1: WB side consumes the head entry.
- out_wb, output, WB_W: head WB control; all zeros when out_valid=0.
- out_dato, output, DATA_W: head memory data.
- out_dir, output, DATA_W: head ALU result.
- out_reg, output, REG_W: head destination register.
- wb_result, output, DATA_W: out_dato when out_wb[0]=1, otherwise out_dir.
- wb_we, output, 1: out_valid & out_wb[1] & ~(SUPPRESS_R0 & out_reg==0).
- occupancy, output, 2: number of held entries (0, 1 or 2).

## Operation

- Storage is two entries:
  - head: drives the out_* ports.
  - skid: holds an overflow entry.
  - Each entry has a valid bit.
- Order is FIFO: the skid entry is always younger than the head entry.
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- in_ready = ~skid_valid.
- Next-state rules, applied per cycle when flush=0:
  - Head empty, accept: entry goes to head.
  - Head full, pop, skid empty, accept: new entry replaces head.
  - Head full, pop, skid full: skid moves to head, skid becomes empty. No accept is possible because in_ready=0.
  - Head full, no pop, accept: entry goes to skid.
  - Head full, pop, no accept, skid empty: head becomes empty.
- There is no combinational path from in_* to out_*, and none from out_ready to in_ready.
- flush=1: both valid bits clear at the clock edge. Any accept or pop in that cycle is ignored, and the payload is not written. Flush has priority over every other event.
- Payload registers of invalid entries may hold stale data, but out_wb is forced to zero whenever out_valid=0.
- wb_result and wb_we are combinational from the head registers only.

## Timing

- Reset (rst_n=0, asynchronous) forces:
  - both valid bits to 0;
  - all payload registers to 0;
  - in_ready=1, out_valid=0, out_wb=0, out_dato=0, out_dir=0, out_reg=0, wb_result=0, wb_we=0, occupancy=0.
- Reset mid-transfer drops all entries immediately; no partial entry survives.
- Latency: an entry accepted at edge N is visible on the out_* ports after edge N, i.e. out_valid in cycle N+1.
- Throughput: one entry per cycle while out_ready=1.
- After one stall cycle with a continuous input stream, the skid entry fills and in_ready falls in the next cycle. When the stall releases, in_ready rises one cycle after the skid drains.
- occupancy is registered and equals head_valid + skid_valid.

## Test plan

- Reset, then stream: rst_n low 3 cycles, then stream 4 entries with out_ready=1 and in_reg=1..4. Required: out_reg shows 1,2,3,4 in consecutive cycles starting one cycle after each accept, occupancy stays 1, and in_ready stays 1.
- Backpressure: out_ready=0 with continuous in_valid carrying entries A,B,C. Required: A and B are accepted, in_ready=0 once occupancy=2, and C is held off. Then raise out_ready=1. Required: pop order A,B,C with no loss and no duplicates.
- Flush: with both entries full, assert flush together with in_valid and out_ready for one cycle. Required: next cycle out_valid=0, occupancy=0, in_ready=1, out_wb=0, and the simultaneous input is dropped.
- Write-back mux and write enable:
  - in_wb=2'b11, in_dato=32'hDEADBEEF, in_dir=32'h00000010, in_reg=7. Required: wb_result=DEADBEEF, wb_we=1.
  - Same entry with in_wb=2'b10. Required: wb_result=00000010.
  - in_reg=0 with SUPPRESS_R0=1. Required: wb_we=0.
- Asynchronous reset mid-stream: drop rst_n between clock edges while occupancy=2. Required: all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: two-entry valid/ready skid buffer with synchronous flush,
// a write-back result mux and a qualified register-file write enable.
module memwb_skid_stage #(
   parameter int unsigned WB_W        = 2,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned REG_W       = 5,
   parameter int unsigned SUPPRESS_R0 = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   in_wb,
   input  logic [DATA_W-1:0] in_dato,
   input  logic [DATA_W-1:0] in_dir,
   input  logic [REG_W-1:0]  in_reg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   out_wb,
   output logic [DATA_W-1:0] out_dato,
   output logic [DATA_W-1:0] out_dir,
   output logic [REG_W-1:0]  out_reg,
   output logic [DATA_W-1:0] wb_result,
   output logic              wb_we,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [DATA_W-1:0] dato;
      logic [DATA_W-1:0] dir;
      logic [REG_W-1:0]  rg;
   } entry_t;

   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   logic       head_valid_q, head_valid_d;
   logic       skid_valid_q, skid_valid_d;
   logic [1:0] occ_q, occ_d;
   entry_t     in_entry;
   logic       accept;
   logic       pop;

   assign in_entry = '{wb: in_wb, dato: in_dato, dir: in_dir, rg: in_reg};
   assign accept   = in_valid & ~skid_valid_q;
   assign pop      = head_valid_q & out_ready;

   // Skid-buffer next state; the skid entry is always younger than the head.
   always_comb begin
      head_d       = head_q;
      skid_d       = skid_q;
      head_valid_d = head_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q) begin
         if (accept) begin
            head_d       = in_entry;
            head_valid_d = 1'b1;
         end
      end else if (pop) begin
         if (skid_valid_q) begin
            head_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            head_d = in_entry;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      occ_d = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q       <= '0;
         skid_q       <= '0;
         head_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         occ_q        <= 2'd0;
      end else begin
         head_q       <= head_d;
         skid_q       <= skid_d;
         head_valid_q <= head_valid_d;
         skid_valid_q <= skid_valid_d;
         occ_q        <= occ_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = head_valid_q;
   assign out_wb    = head_valid_q ? head_q.wb : '0;
   assign out_dato  = head_q.dato;
   assign out_dir   = head_q.dir;
   assign out_reg   = head_q.rg;
   assign occupancy = occ_q;

   // Bit 0 of WB selects memory data, bit 1 requests a register write.
   assign wb_result = out_wb[0] ? head_q.dato : head_q.dir;
   assign wb_we     = head_valid_q & out_wb[1]
                    & ~((SUPPRESS_R0 != 0) && (head_q.rg == '0));

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_memwb_skid_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_wb;
   logic [31:0] in_dato;
   logic [31:0] in_dir;
   logic [4:0]  in_reg;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_wb;
   logic [31:0] out_dato;
   logic [31:0] out_dir;
   logic [4:0]  out_reg;
   logic [31:0] wb_result;
   logic        wb_we;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;

   memwb_skid_stage #(.WB_W(2), .DATA_W(32), .REG_W(5), .SUPPRESS_R0(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wb(in_wb), .in_dato(in_dato), .in_dir(in_dir), .in_reg(in_reg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wb(out_wb), .out_dato(out_dato), .out_dir(out_dir), .out_reg(out_reg),
      .wb_result(wb_result), .wb_we(wb_we), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] dato;
      logic [31:0] dir;
      logic [4:0]  rg;
   } ent_t;

   ent_t mq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an ordered list of at most two entries.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         automatic bit acc = in_valid && (mq.size() < 2);
         automatic bit pp  = (mq.size() > 0) && out_ready;
         automatic ent_t e;
         e.wb = in_wb; e.dato = in_dato; e.dir = in_dir; e.rg = in_reg;
         if (pp)  void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
         chk("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("m_out_wb", 64'(out_wb), 64'(mq[0].wb));
            chk("m_out_dato", 64'(out_dato), 64'(mq[0].dato));
            chk("m_out_dir", 64'(out_dir), 64'(mq[0].dir));
            chk("m_out_reg", 64'(out_reg), 64'(mq[0].rg));
            chk("m_wb_result", 64'(wb_result), 64'(mq[0].wb[0] ? mq[0].dato : mq[0].dir));
            chk("m_wb_we", 64'(wb_we), 64'(mq[0].wb[1] && (mq[0].rg != 5'd0)));
         end else begin
            chk("m_out_wb_idle", 64'(out_wb), 64'd0);
            chk("m_wb_we_idle", 64'(wb_we), 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] wb, input logic [31:0] d,
                        input logic [31:0] a, input logic [4:0] r);
      in_valid = v; in_wb = wb; in_dato = d; in_dir = a; in_reg = r;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_wb"}, 64'(out_wb), 64'd0);
      chk({tag, "_out_dato"}, 64'(out_dato), 64'd0);
      chk({tag, "_out_dir"}, 64'(out_dir), 64'd0);
      chk({tag, "_out_reg"}, 64'(out_reg), 64'd0);
      chk({tag, "_wb_result"}, 64'(wb_result), 64'd0);
      chk({tag, "_wb_we"}, 64'(wb_we), 64'd0);
      chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      repeat (3) step();
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Stream four entries straight through.
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 2'b10, 32'(i * 16), 32'(i), 5'(i));
         step();
         chk("stream_reg", 64'(out_reg), 64'(i));
         chk("stream_occ", 64'(occupancy), 64'd1);
         chk("stream_rdy", 64'(in_ready), 64'd1);
      end
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      step();
      chk("stream_drain", 64'(out_valid), 64'd0);

      // Backpressure: A and B accepted, C held off until space frees up.
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 32'hA0, 32'hA1, 5'd10);
      step();
      chk("bp_occ1", 64'(occupancy), 64'd1);
      drive(1'b1, 2'b11, 32'hB0, 32'hB1, 5'd11);
      step();
      chk("bp_occ2", 64'(occupancy), 64'd2);
      chk("bp_rdy_low", 64'(in_ready), 64'd0);
      drive(1'b1, 2'b11, 32'hC0, 32'hC1, 5'd12);
      step();
      chk("bp_hold_head", 64'(out_reg), 64'd10);
      chk("bp_hold_occ", 64'(occupancy), 64'd2);
      out_ready = 1'b1;
      step();
      chk("bp_pop_b", 64'(out_reg), 64'd11);
      chk("bp_rdy_back", 64'(in_ready), 64'd1);
      step();
      chk("bp_pop_c", 64'(out_reg), 64'd12);
      chk("bp_pop_c_dato", 64'(out_dato), 64'hC0);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      step();
      chk("bp_empty", 64'(occupancy), 64'd0);

      // Flush while full, with a simultaneous accept and pop offered.
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 32'hD0, 32'hD1, 5'd20);
      step();
      drive(1'b1, 2'b11, 32'hE0, 32'hE1, 5'd21);
      step();
      chk("fl_full", 64'(occupancy), 64'd2);
      flush = 1'b1; out_ready = 1'b1;
      drive(1'b1, 2'b11, 32'hF0, 32'hF1, 5'd22);
      step();
      flush = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_rdy", 64'(in_ready), 64'd1);
      chk("fl_wb", 64'(out_wb), 64'd0);
      step();
      chk("fl_dropped", 64'(out_valid), 64'd0);

      // Write-back mux and write enable qualification.
      drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h00000010, 5'd7);
      step();
      chk("wb_mem_res", 64'(wb_result), 64'hDEADBEEF);
      chk("wb_mem_we", 64'(wb_we), 64'd1);
      drive(1'b1, 2'b10, 32'hDEADBEEF, 32'h00000010, 5'd7);
      step();
      chk("wb_alu_res", 64'(wb_result), 64'h00000010);
      chk("wb_alu_we", 64'(wb_we), 64'd1);
      drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h00000010, 5'd0);
      step();
      chk("wb_r0_we", 64'(wb_we), 64'd0);
      drive(1'b1, 2'b01, 32'hDEADBEEF, 32'h00000010, 5'd7);
      step();
      chk("wb_nowr_we", 64'(wb_we), 64'd0);
      chk("wb_nowr_res", 64'(wb_result), 64'hDEADBEEF);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      step();

      // Asynchronous reset between edges while both entries are held.
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 32'h12345678, 32'h9ABCDEF0, 5'd30);
      step();
      drive(1'b1, 2'b11, 32'h11111111, 32'h22222222, 5'd31);
      step();
      chk("ar_full", 64'(occupancy), 64'd2);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      step();
      rst_n = 1'b1;

      // Recovery after reset.
      out_ready = 1'b1;
      drive(1'b1, 2'b10, 32'h5, 32'h6, 5'd9);
      step();
      chk("rec_reg", 64'(out_reg), 64'd9);
      chk("rec_res", 64'(wb_result), 64'h6);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
